// File: rtl/acc_sha256.sv
// acc_sha256: memory-mapped SHA-256 compression engine.
// Software loads sixteen message words, writes a start command, and the
// block runs 64 rounds and then streams the eight digest words out.
module acc_sha256 (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [4:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] data_out,
  output logic [3:0]  writeaddress
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state;
  logic [31:0] m    [0:15];
  logic [31:0] w    [0:15];
  logic [31:0] hash [0:7];
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [5:0]  t;
  logic [3:0]  out_cnt;

  logic        wr_en;
  logic [31:0] big_sigma1, big_sigma0, ch, maj, t1, t2;
  logic [31:0] small_sigma0, small_sigma1, w_new;

  assign wr_en = chipselect & write;

  // Round function and next schedule word; w[0] is always W_t for the current round.
  always_comb begin
    big_sigma1   = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    big_sigma0   = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    ch           = (e & f) ^ (~e & g);
    maj          = (a & b) ^ (a & c) ^ (b & c);
    t1           = h + big_sigma1 + ch + K[t] + w[0];
    t2           = big_sigma0 + maj;
    small_sigma0 = rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3);
    small_sigma1 = rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10);
    w_new        = small_sigma1 + w[9] + small_sigma0 + w[0];
  end

  // Control FSM, message registers, working state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      data_out     <= '0;
      writeaddress <= '0;
      t            <= '0;
      out_cnt      <= '0;
      a <= '0; b <= '0; c <= '0; d <= '0;
      e <= '0; f <= '0; g <= '0; h <= '0;
      for (int i = 0; i < 16; i++) begin
        m[i] <= '0;
        w[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        hash[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          data_out     <= '0;
          writeaddress <= '0;
          if (wr_en && (address[4] == 1'b0)) begin
            m[address[3:0]] <= writedata;
          end
          if (wr_en && (address == 5'd16) && writedata[0]) begin
            a <= H_INIT[0]; b <= H_INIT[1]; c <= H_INIT[2]; d <= H_INIT[3];
            e <= H_INIT[4]; f <= H_INIT[5]; g <= H_INIT[6]; h <= H_INIT[7];
            for (int i = 0; i < 16; i++) begin
              w[i] <= m[i];
            end
            t     <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) begin
            w[i] <= w[i+1];
          end
          w[15] <= w_new;
          t     <= t + 6'd1;
          if (t == 6'd63) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          hash[0] <= H_INIT[0] + a;
          hash[1] <= H_INIT[1] + b;
          hash[2] <= H_INIT[2] + c;
          hash[3] <= H_INIT[3] + d;
          hash[4] <= H_INIT[4] + e;
          hash[5] <= H_INIT[5] + f;
          hash[6] <= H_INIT[6] + g;
          hash[7] <= H_INIT[7] + h;
          out_cnt <= '0;
          state   <= OUT;
        end
        OUT: begin
          if (out_cnt == 4'd8) begin
            data_out     <= '0;
            writeaddress <= '0;
            state        <= IDLE;
          end else begin
            data_out     <= hash[out_cnt[2:0]];
            writeaddress <= {1'b1, out_cnt[2:0]};
            out_cnt      <= out_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sha256.sv
// tb_acc_sha256: table-driven and sequence checks of acc_sha256 against a
// loop-based SHA-256 reference model.
module tb_acc_sha256;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] data_out;
  logic [3:0]  writeaddress;

  int vectors;
  int miscompares;

  localparam logic [31:0] H_REF [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_REF [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] MINE_BLOCK = {
    32'h000000dc, 32'h00000000, 32'h3239b540, 32'h3339b233,
    32'h30b33239, 32'hb335b239, 32'hb5b239b5, 32'h39b0b533,
    32'h33353235, 32'hb530b5b6, 32'h30b335b2, 32'h35b239b5,
    32'h39b0b533, 32'h3239b0b3, 32'h00000000, 32'h000001bf
  };
  localparam logic [255:0] MINE_DIGEST =
    256'h80cab0c8ef5701aed57f628fd04511fd4f2040ba721acb80c48650a4677f47be;

  typedef struct {
    logic [511:0] blk;
    logic [255:0] digest;
  } vec_t;

  vec_t vecs [6];

  acc_sha256 dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .data_out     (data_out),
    .writeaddress (writeaddress)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one block from the initial hash values.
  function automatic logic [255:0] sha256_ref(input logic [511:0] blk);
    logic [31:0] wv [0:63];
    logic [31:0] r  [0:7];
    logic [31:0] s0, s1, tmp1, tmp2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) wv[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(wv[i-15], 7) ^ ror(wv[i-15], 18) ^ (wv[i-15] >> 3);
      s1 = ror(wv[i-2], 17) ^ ror(wv[i-2], 19) ^ (wv[i-2] >> 10);
      wv[i] = s1 + wv[i-7] + s0 + wv[i-16];
    end
    for (int i = 0; i < 8; i++) r[i] = H_REF[i];
    for (int i = 0; i < 64; i++) begin
      tmp1 = r[7] + (ror(r[4], 6) ^ ror(r[4], 11) ^ ror(r[4], 25))
           + ((r[4] & r[5]) ^ (~r[4] & r[6])) + K_REF[i] + wv[i];
      tmp2 = (ror(r[0], 2) ^ ror(r[0], 13) ^ ror(r[0], 22))
           + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
      for (int k = 7; k > 0; k--) r[k] = r[k-1];
      r[4] = r[4] + tmp1;
      r[0] = tmp1 + tmp2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = H_REF[i] + r[i];
    return res;
  endfunction

  task automatic check_output(input string name, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input logic cs);
    @(negedge clk);
    chipselect = cs;
    write      = 1'b1;
    address    = addr;
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [511:0] blk);
    for (int k = 0; k < 16; k++) bus_write(5'(k), blk[511 - 32*k -: 32], 1'b1);
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      check_output(name, {writeaddress, data_out}, 36'h0);
    end
  endtask

  // Starts a hash and checks every cycle against the expected output timeline.
  // busy_at > 0 injects a message write and a second start at that cycle.
  task automatic run_hash(input string name, input logic [255:0] exp_digest,
                          input int cycles, input int busy_at);
    logic [35:0] exp_v;
    int j;
    bus_write(5'd16, 32'h1, 1'b1);
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n >= 66 && n <= 73) begin
        j = n - 66;
        exp_v = {1'b1, 3'(j), exp_digest[255 - 32*j -: 32]};
      end else begin
        exp_v = '0;
      end
      check_output($sformatf("%s cyc%0d", name, n), {writeaddress, data_out}, exp_v);
      if (busy_at > 0 && n == busy_at) begin
        chipselect = 1'b1; write = 1'b1; address = 5'd3; writedata = 32'hffffffff;
      end else if (busy_at > 0 && n == busy_at + 1) begin
        chipselect = 1'b1; write = 1'b1; address = 5'd16; writedata = 32'h1;
      end else begin
        chipselect = 1'b0; write = 1'b0;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    chipselect = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;

    vecs[0].blk = ABC_BLOCK;  vecs[0].digest = ABC_DIGEST;
    vecs[1].blk = MINE_BLOCK; vecs[1].digest = MINE_DIGEST;
    for (int v = 2; v < 6; v++) begin
      for (int k = 0; k < 16; k++) vecs[v].blk[511 - 32*k -: 32] = $urandom;
      vecs[v].digest = sha256_ref(vecs[v].blk);
    end

    $display("[TB] reset hold with random writes");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = (i % 4 == 0) ? 5'd16 : 5'($urandom_range(0, 15));
      writedata  = (i % 4 == 0) ? 32'h1 : $urandom;
      check_output("reset_hold", {writeaddress, data_out}, 36'h0);
    end
    @(negedge clk);
    chipselect = 1'b0;
    write = 1'b0;
    reset = 1'b1;
    check_idle("post_reset", 80);
    run_hash("zero_block", sha256_ref(512'h0), 80, 0);

    $display("[TB] table vectors");
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].blk);
      run_hash($sformatf("vec%0d", v), vecs[v].digest, 80, 0);
    end

    $display("[TB] busy write protection");
    apply_stimulus(MINE_BLOCK);
    run_hash("busy", MINE_DIGEST, 160, 10);
    run_hash("rehash", MINE_DIGEST, 80, 0);

    $display("[TB] ignored commands");
    for (int a = 17; a < 32; a++) bus_write(5'(a), $urandom, 1'b1);
    bus_write(5'd16, 32'h0, 1'b1);
    bus_write(5'd16, $urandom & 32'hfffffffe, 1'b1);
    bus_write(5'd16, 32'h1, 1'b0);
    check_idle("ignored", 80);
    run_hash("after_ignored", MINE_DIGEST, 80, 0);

    $display("[TB] asynchronous clear during output");
    bus_write(5'd16, 32'h1, 1'b1);
    repeat (68) @(posedge clk);
    @(negedge clk);
    check_output("out_word2", {writeaddress, data_out}, {4'b1010, MINE_DIGEST[191:160]});
    #2 reset = 1'b0;
    #1 check_output("async_clear", {writeaddress, data_out}, 36'h0);
    @(negedge clk);
    reset = 1'b1;
    check_idle("post_clear", 20);

    $display("[TB] mid-hash abort at round 30");
    apply_stimulus(MINE_BLOCK);
    bus_write(5'd16, 32'h1, 1'b1);
    repeat (31) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_output("abort_round30", {writeaddress, data_out}, 36'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_idle("post_abort", 80);
    apply_stimulus(ABC_BLOCK);
    run_hash("abc_after_abort", ABC_DIGEST, 80, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
